sort_memory: RTL and testbench
==============================

Name: sort_memory

Overview:
- Word-addressed memory slave on the downstream side of the sort circuit's memory interface.
- Terminates the AR/R (read) and AW/W/B (write) channels with valid/ready handshakes.
- Holds the array being sorted and returns OKAY or SLVERR responses.
- Programmable wait states let the bench stress the sorter's handshake tolerance.

Parameters:
- ADDR_WDTH, 4: address width in words.
- DATA_WDTH, 32: word width.
- RESP_WDTH, 1: response width.
- MEM_DEPTH, 16: implemented words, must be <= 2**ADDR_WDTH; addresses >= MEM_DEPTH are out of range.
- RD_WAIT, 0: extra cycles between AR accept and r_valid, range 0..15.
- WR_WAIT, 0: extra cycles between write commit and b_valid, range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ar_valid  in  1  read address valid.
- ar_ready  out  1  read address accepted.
- ar_address  in  ADDR_WDTH  read word address.
- r_valid  out  1  read data valid.
- r_ready  in  1  read data consumed.
- r_data  out  DATA_WDTH  read word.
- r_resp  out  RESP_WDTH  0 = OKAY, 1 = SLVERR.
- aw_valid  in  1  write address valid.
- aw_ready  out  1  write address accepted.
- aw_address  in  ADDR_WDTH  write word address.
- w_valid  in  1  write data valid.
- w_ready  out  1  write data accepted.
- w_data  in  DATA_WDTH  write word.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response consumed.
- b_resp  out  RESP_WDTH  0 = OKAY, 1 = SLVERR.

Behaviour:
- Reset (async assert, sync release): all outputs 0; both FSMs go to IDLE; latched AW/W are dropped; wait counters 0. Memory array is not reset and holds its previous contents. A reset mid-transaction abandons it; no response is issued after release.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
- R_IDLE: ar_ready=1. On ar_valid&&ar_ready, sample the array at ar_address (value before any same-edge write) into the r_data register and set r_resp.
  - RD_WAIT=0: go to R_RESP.
  - RD_WAIT>0: load counter with RD_WAIT and go to R_WAIT.
- R_WAIT: ar_ready=0; decrement counter; go to R_RESP when counter reaches 1.
- R_RESP: r_valid=1; r_data and r_resp stay stable until r_valid&&r_ready, then return to R_IDLE with r_valid=0.
- Read latency: r_valid rises 1+RD_WAIT cycles after the AR handshake edge. Maximum throughput is one read per 2+RD_WAIT cycles. ar_ready is never combinationally dependent on r_ready.
- Write path: AW and W are latched independently in any order or in the same cycle.
  - aw_ready=1 while no AW is latched and the write FSM is in W_IDLE; w_ready likewise for W.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
- W_IDLE: once both AW and W are latched (including the cycle both handshake together), commit on the next edge. The array is written only if the address < MEM_DEPTH. Latches clear, b_resp is set, and the FSM goes to W_WAIT (WR_WAIT>0) or W_RESP.
- W_RESP: b_valid=1 and stable until b_ready; then W_IDLE.
- Out of range address (>= MEM_DEPTH): read returns r_data=0, r_resp=1; write leaves the array unchanged, b_resp=1. The handshake completes normally.
- Read/write collision: the read and write FSMs run concurrently. A read accepted on the same edge as a write commit to the same address returns the old data. Any read accepted after the commit edge returns the new data.
- Inputs are not required to be stable before a handshake. Only values present at the handshake edge are used.

Decomposition:
- Package sort_mem_pkg holds:
  - RESP_OKAY=0 and RESP_SLVERR=1.
  - Read and write FSM state encodings (2-bit localparam enums).
  - Wait counter width 4.
- Sub-module sort_mem_array: synchronous-write, async-read word array, MEM_DEPTH x DATA_WDTH, with one write port and one read port. Range checks stay in the parent.

Test Plan:
- Reset, RD_WAIT=0: write 0xDEADBEEF to addr 3 with AW and W in the same cycle, then read addr 3 -> b_valid one cycle after commit with b_resp=0; r_valid one cycle after AR accept with r_data=0xDEADBEEF, r_resp=0.
- W three cycles before AW (data 0x11, addr 5) -> w_ready falls after the W handshake; the write commits the edge after AW; readback of addr 5 = 0x11.
- RD_WAIT=3, read addr 0 holding 0x7, r_ready held low 4 cycles -> r_valid rises 4 cycles after accept; r_data stays 0x7 and ar_ready stays 0 until the r handshake.
- MEM_DEPTH=12: write 0xAA to addr 13, then read addr 13 -> b_resp=1, r_resp=1, r_data=0; addr 1 (0x55 previously) remains 0x55.
- Addr 2 holds 0x1. AR addr 2 accepted on the same edge as a write commit of 0x2 to addr 2 -> r_data=0x1; a following read -> 0x2.
- Assert rst_n low while r_valid=1 and an AW is latched -> all valids and readies go to 0 immediately. After release, no stale r_valid or b_valid appears, and ar_ready/aw_ready/w_ready return to 1.

Source files
------------

// File: rtl/sort_mem_pkg.sv
// Shared constants and FSM encodings for the sort circuit's memory slave.
// Response codes are plain integers so each user can size them to its own response width.
package sort_mem_pkg;

    localparam int CNT_WDTH    = 4;
    localparam int RESP_OKAY   = 0;
    localparam int RESP_SLVERR = 1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/sort_mem_array.sv
// Word array with one synchronous write port and one asynchronous read port.
// Address range checks are the parent's job; only in-range addresses reach the write port.
module sort_mem_array #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int MEM_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_WDTH-1:0] wr_addr,
    input  logic [DATA_WDTH-1:0] wr_data,
    input  logic [ADDR_WDTH-1:0] rd_addr,
    output logic [DATA_WDTH-1:0] rd_data
);

    logic [DATA_WDTH-1:0] mem [MEM_DEPTH];

    // NOTE: the array has no reset; its contents survive rst_n and only the control path restarts.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sort_memory.sv
// Word-addressed memory slave terminating AR/R and AW/W/B handshakes for the sorter.
// Independent read and write FSMs, each with a programmable wait before its response.
module sort_memory
    import sort_mem_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int MEM_DEPTH = 16,
    parameter int RD_WAIT   = 0,
    parameter int WR_WAIT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [ADDR_WDTH-1:0] ar_address,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_WDTH-1:0] aw_address,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [RESP_WDTH-1:0] b_resp
);

    localparam logic [ADDR_WDTH:0] DEPTH_L = (ADDR_WDTH + 1)'(MEM_DEPTH);

    rd_state_e            rd_state, rd_next;
    wr_state_e            wr_state, wr_next;
    logic [CNT_WDTH-1:0]  rd_cnt, wr_cnt;
    logic                 live_q;
    logic                 aw_held, w_held;
    logic [ADDR_WDTH-1:0] aw_addr_q;
    logic [DATA_WDTH-1:0] w_data_q;
    logic [DATA_WDTH-1:0] arr_rd_data;
    logic                 ar_hs, aw_hs, w_hs, commit;
    logic                 rd_in_range, wr_in_range;

    // Readies stay low until the first edge after reset release, so every output is 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    assign ar_ready = live_q && (rd_state == R_IDLE);
    assign aw_ready = live_q && !aw_held && (wr_state == W_IDLE);
    assign w_ready  = live_q && !w_held  && (wr_state == W_IDLE);
    assign r_valid  = (rd_state == R_RESP);
    assign b_valid  = (wr_state == W_RESP);

    assign ar_hs       = ar_valid && ar_ready;
    assign aw_hs       = aw_valid && aw_ready;
    assign w_hs        = w_valid  && w_ready;
    assign commit      = (wr_state == W_IDLE) && aw_held && w_held;
    assign rd_in_range = {1'b0, ar_address} < DEPTH_L;
    assign wr_in_range = {1'b0, aw_addr_q}  < DEPTH_L;

    sort_mem_array #(
        .ADDR_WDTH (ADDR_WDTH),
        .DATA_WDTH (DATA_WDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (commit && wr_in_range),
        .wr_addr (aw_addr_q),
        .wr_data (w_data_q),
        .rd_addr (ar_address),
        .rd_data (arr_rd_data)
    );

    // ---------------- read path ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= R_IDLE;
        else        rd_state <= rd_next;
    end

    // NOTE: rd_next is given a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE: if (ar_hs) rd_next = (RD_WAIT == 0) ? R_RESP : R_WAIT;
            R_WAIT: if (rd_cnt == CNT_WDTH'(1)) rd_next = R_RESP;
            R_RESP: if (r_ready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            r_data <= '0;
            r_resp <= '0;
        end else if (ar_hs) begin
            rd_cnt <= CNT_WDTH'(RD_WAIT);
            r_data <= rd_in_range ? arr_rd_data : '0;
            r_resp <= rd_in_range ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_SLVERR);
        end else if (rd_state == R_WAIT) begin
            rd_cnt <= rd_cnt - CNT_WDTH'(1);
        end
    end

    // ---------------- write path ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_state <= W_IDLE;
        else        wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE: if (commit) wr_next = (WR_WAIT == 0) ? W_RESP : W_WAIT;
            W_WAIT: if (wr_cnt == CNT_WDTH'(1)) wr_next = W_RESP;
            W_RESP: if (b_ready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // AW and W are captured independently; the commit cycle consumes both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= aw_address;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= w_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            b_resp <= '0;
        end else if (commit) begin
            wr_cnt <= CNT_WDTH'(WR_WAIT);
            b_resp <= wr_in_range ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_SLVERR);
        end else if (wr_state == W_WAIT) begin
            wr_cnt <= wr_cnt - CNT_WDTH'(1);
        end
    end

endmodule

// File: tb/tb_sort_memory.sv
// Bench for sort_memory: two instances (no-wait/12-word and waited/16-word) driven by
// directed tasks, checked every cycle against a transaction-level model plus literal expectations.
module tb_sort_memory;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int ND = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          ar_valid   [ND];
    logic          ar_ready   [ND];
    logic [AW-1:0] ar_address [ND];
    logic          r_valid    [ND];
    logic          r_ready    [ND];
    logic [DW-1:0] r_data     [ND];
    logic [0:0]    r_resp     [ND];
    logic          aw_valid   [ND];
    logic          aw_ready   [ND];
    logic [AW-1:0] aw_address [ND];
    logic          w_valid    [ND];
    logic          w_ready    [ND];
    logic [DW-1:0] w_data     [ND];
    logic          b_valid    [ND];
    logic          b_ready    [ND];
    logic [0:0]    b_resp     [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sort_memory #(
            .ADDR_WDTH (AW),
            .DATA_WDTH (DW),
            .RESP_WDTH (1),
            .MEM_DEPTH (g == 0 ? 12 : 16),
            .RD_WAIT   (g == 0 ? 0 : 3),
            .WR_WAIT   (g == 0 ? 0 : 2)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .ar_valid   (ar_valid[g]),
            .ar_ready   (ar_ready[g]),
            .ar_address (ar_address[g]),
            .r_valid    (r_valid[g]),
            .r_ready    (r_ready[g]),
            .r_data     (r_data[g]),
            .r_resp     (r_resp[g]),
            .aw_valid   (aw_valid[g]),
            .aw_ready   (aw_ready[g]),
            .aw_address (aw_address[g]),
            .w_valid    (w_valid[g]),
            .w_ready    (w_ready[g]),
            .w_data     (w_data[g]),
            .b_valid    (b_valid[g]),
            .b_ready    (b_ready[g]),
            .b_resp     (b_resp[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int depth_of(input int d);   return (d == 0) ? 12 : 16; endfunction
    function automatic int rd_wait_of(input int d); return (d == 0) ? 0 : 3;   endfunction
    function automatic int wr_wait_of(input int d); return (d == 0) ? 0 : 2;   endfunction

    logic [DW-1:0] mem_m [ND][16];
    bit            live_m   [ND];
    bit            rd_busy  [ND];
    int            rd_dly   [ND];
    logic [DW-1:0] exp_rdat [ND];
    logic          exp_rrsp [ND];
    bit            b_busy   [ND];
    int            b_dly    [ND];
    logic          exp_brsp [ND];
    bit            aw_got   [ND];
    bit            w_got    [ND];
    int            aw_a     [ND];
    logic [DW-1:0] w_d      [ND];

    task automatic model_step(input int d);
        bit exp_rv, exp_arr, exp_bv, exp_awr, exp_wr, commit;
        if (!rst_n) begin
            check($sformatf("d%0d outputs in reset", d),
                  {ar_ready[d], r_valid[d], r_data[d], r_resp[d],
                   aw_ready[d], w_ready[d], b_valid[d], b_resp[d]}, '0);
            live_m[d] = 0; rd_busy[d] = 0; b_busy[d] = 0;
            aw_got[d] = 0; w_got[d] = 0;
        end else begin
            exp_rv  = rd_busy[d] && rd_dly[d] == 0;
            exp_arr = live_m[d] && !rd_busy[d];
            exp_bv  = b_busy[d] && b_dly[d] == 0;
            exp_awr = live_m[d] && !aw_got[d] && !b_busy[d];
            exp_wr  = live_m[d] && !w_got[d]  && !b_busy[d];
            check($sformatf("d%0d r_valid", d),  r_valid[d],  exp_rv);
            check($sformatf("d%0d ar_ready", d), ar_ready[d], exp_arr);
            check($sformatf("d%0d b_valid", d),  b_valid[d],  exp_bv);
            check($sformatf("d%0d aw_ready", d), aw_ready[d], exp_awr);
            check($sformatf("d%0d w_ready", d),  w_ready[d],  exp_wr);
            if (exp_rv) begin
                check($sformatf("d%0d r_data", d), r_data[d], exp_rdat[d]);
                check($sformatf("d%0d r_resp", d), r_resp[d], exp_rrsp[d]);
            end
            if (exp_bv) check($sformatf("d%0d b_resp", d), b_resp[d], exp_brsp[d]);

            commit = aw_got[d] && w_got[d];
            // Reads accepted on a commit edge see the memory as it was before the write.
            if (exp_arr && ar_valid[d]) begin
                rd_busy[d]  = 1;
                rd_dly[d]   = rd_wait_of(d);
                exp_rrsp[d] = (int'(ar_address[d]) >= depth_of(d));
                exp_rdat[d] = exp_rrsp[d] ? '0 : mem_m[d][ar_address[d]];
            end else if (rd_busy[d]) begin
                if (exp_rv) begin
                    if (r_ready[d]) rd_busy[d] = 0;
                end else rd_dly[d]--;
            end
            if (b_busy[d]) begin
                if (exp_bv) begin
                    if (b_ready[d]) b_busy[d] = 0;
                end else b_dly[d]--;
            end
            if (exp_awr && aw_valid[d]) begin aw_got[d] = 1; aw_a[d] = int'(aw_address[d]); end
            if (exp_wr && w_valid[d])   begin w_got[d] = 1;  w_d[d] = w_data[d]; end
            if (commit) begin
                exp_brsp[d] = (aw_a[d] >= depth_of(d));
                if (!exp_brsp[d]) mem_m[d][aw_a[d]] = w_d[d];
                b_busy[d] = 1; b_dly[d] = wr_wait_of(d);
                aw_got[d] = 0; w_got[d] = 0;
            end
            live_m[d] = 1;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) model_step(d);
    end

    // ---------------- stimulus tasks (enter and leave at posedge+1) ----------------
    task automatic wr(input int d, input int addr, input logic [DW-1:0] data, input int w_lead,
                      output int lat, output logic resp);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w, got = 0;
        int cyc = 0;
        aw_address[d] = AW'(addr);
        w_data[d]     = data;
        while (!(aw_done && w_done) && cyc < 60) begin
            w_valid[d]  = !w_done;
            aw_valid[d] = !aw_done && cyc >= w_lead;
            @(negedge clk);
            hs_aw = aw_valid[d] && aw_ready[d];
            hs_w  = w_valid[d]  && w_ready[d];
            if (w_done && !aw_done) check($sformatf("d%0d w_ready low while W held", d), w_ready[d], 1'b0);
            @(posedge clk); #1;
            aw_done |= hs_aw; w_done |= hs_w; cyc++;
        end
        aw_valid[d] = 0; w_valid[d] = 0;
        if (!(aw_done && w_done)) check($sformatf("d%0d write handshake timeout", d), 0, 1);
        lat = 0; resp = 1'bx;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); lat++;
            got = b_valid[d]; resp = b_resp[d];
        end
        if (!got) check($sformatf("d%0d b_valid timeout", d), 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic rd(input int d, input int addr, input int hold,
                      output logic [DW-1:0] data, output logic resp, output int lat);
        bit hs = 0, got = 0;
        r_ready[d] = 0; ar_valid[d] = 1; ar_address[d] = AW'(addr);
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk); hs = ar_ready[d];
            @(posedge clk); #1;
        end
        ar_valid[d] = 0;
        if (!hs) check($sformatf("d%0d ar handshake timeout", d), 0, 1);
        lat = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); lat++; got = r_valid[d];
        end
        if (!got) check($sformatf("d%0d r_valid timeout", d), 0, 1);
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
        r_ready[d] = 1;
        @(negedge clk);
        data = r_data[d]; resp = r_resp[d];
        check($sformatf("d%0d r_valid held until r_ready", d), r_valid[d], 1'b1);
        @(posedge clk); #1;
        r_ready[d] = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [DW-1:0] data;
        logic          resp;
        int            lat;

        for (int d = 0; d < ND; d++) begin
            ar_valid[d] = 0; ar_address[d] = '0; r_ready[d] = 0;
            aw_valid[d] = 0; aw_address[d] = '0; w_valid[d] = 0; w_data[d] = '0;
            b_ready[d] = 1;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Same-cycle AW+W write, then readback, no wait states.
        wr(0, 3, 32'hDEADBEEF, 0, lat, resp);
        check("t1 b latency from AW/W", lat, 2);
        check("t1 b_resp", resp, 1'b0);
        rd(0, 3, 0, data, resp, lat);
        check("t1 r latency", lat, 1);
        check("t1 r_data", data, 32'hDEADBEEF);
        check("t1 r_resp", resp, 1'b0);

        // W three cycles ahead of AW.
        wr(0, 5, 32'h11, 3, lat, resp);
        check("t2 b latency from AW", lat, 2);
        rd(0, 5, 0, data, resp, lat);
        check("t2 r_data", data, 32'h11);

        // Wait states on both channels, r_ready held off.
        wr(1, 0, 32'h7, 0, lat, resp);
        check("t3 b latency with WR_WAIT=2", lat, 4);
        rd(1, 0, 3, data, resp, lat);
        check("t3 r latency with RD_WAIT=3", lat, 4);
        check("t3 r_data", data, 32'h7);

        // Range boundary on the 12-word instance.
        wr(0, 1, 32'h55, 0, lat, resp);
        wr(0, 13, 32'hAA, 0, lat, resp);
        check("t4 b_resp addr 13", resp, 1'b1);
        rd(0, 13, 0, data, resp, lat);
        check("t4 r_data addr 13", data, 32'h0);
        check("t4 r_resp addr 13", resp, 1'b1);
        rd(0, 1, 0, data, resp, lat);
        check("t4 addr 1 untouched", data, 32'h55);
        wr(0, 11, 32'hB11, 0, lat, resp);
        check("t4 b_resp addr 11", resp, 1'b0);
        wr(0, 12, 32'hC12, 0, lat, resp);
        check("t4 b_resp addr 12", resp, 1'b1);
        rd(0, 11, 0, data, resp, lat);
        check("t4 r_data addr 11", data, 32'hB11);

        // AR accepted on the same edge the write to the same address commits.
        wr(0, 2, 32'h1, 0, lat, resp);
        aw_valid[0] = 1; aw_address[0] = 4'd2; w_valid[0] = 1; w_data[0] = 32'h2;
        @(negedge clk);
        check("t5 aw/w accepted", {aw_ready[0], w_ready[0]}, 2'b11);
        @(posedge clk); #1;
        aw_valid[0] = 0; w_valid[0] = 0;
        ar_valid[0] = 1; ar_address[0] = 4'd2; r_ready[0] = 0;
        @(negedge clk);
        check("t5 ar accepted on commit edge", ar_ready[0], 1'b1);
        @(posedge clk); #1;
        ar_valid[0] = 0;
        @(negedge clk);
        check("t5 collision r_valid", r_valid[0], 1'b1);
        check("t5 collision old data", r_data[0], 32'h1);
        @(posedge clk); #1 r_ready[0] = 1;
        @(posedge clk); #1 r_ready[0] = 0;
        rd(0, 2, 0, data, resp, lat);
        check("t5 following read new data", data, 32'h2);

        // Reset while r_valid is up and an AW is latched.
        ar_valid[0] = 1; ar_address[0] = 4'd3; aw_valid[0] = 1; aw_address[0] = 4'd4;
        @(posedge clk); #1;
        ar_valid[0] = 0; aw_valid[0] = 0;
        @(negedge clk);
        check("t6 r_valid before reset", r_valid[0], 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check("t6 valids/readies in reset",
                 {ar_ready[0], aw_ready[0], w_ready[0], r_valid[0], b_valid[0]}, 5'b00000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("t6 after release",
                 {ar_ready[0], aw_ready[0], w_ready[0], r_valid[0], b_valid[0]}, 5'b11100);
        rd(0, 3, 0, data, resp, lat);
        check("t6 memory survives reset", data, 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
